// File: rtl/mips_pkg.sv
// Shared constants, word type and FSM state encoding for the MIPS issue sequencer.
package mips_pkg;
   localparam int WORD_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_HALT  = 6'h3F;
   localparam logic [5:0] FUNC_ADD = 6'h20;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_READ,
      ST_EXEC,
      ST_WB,
      ST_DONE
   } state_t;
endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port, $0 hardwired to zero.
module mips_regfile
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       we,
   input  logic [4:0] waddr,
   input  word_t      wdata,
   input  logic [4:0] raddr_a,
   input  logic [4:0] raddr_b,
   output word_t      rdata_a,
   output word_t      rdata_b
);
   word_t regs [32];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && (waddr != 5'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == 5'd0) ? '0 : regs[raddr_a];
   assign rdata_b = (raddr_b == 5'd0) ? '0 : regs[raddr_b];
endmodule

// File: rtl/mips_issue_sequencer.sv
// Multi-cycle issue sequencer: fetches, decodes and writes back one instruction every five cycles.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | imem_addr holds pc, memory read in flight
// DECODE | latch instruction word, detect halt
// READ   | load rs/rt operands from the register file
// EXEC   | core settles; result captured at the end
// WB     | write strobe for one cycle, pc advances
// DONE   | one-cycle done pulse
module mips_issue_sequencer
   import mips_pkg::*;
#(
   parameter int          IMEM_DEPTH  = 256,
   parameter logic [5:0]  HALT_OPCODE = OP_HALT,
   localparam int         AW          = $clog2(IMEM_DEPTH)
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic [AW-1:0] imem_addr,
   input  word_t         imem_data,
   output word_t         instruction,
   output word_t         rs_content,
   output word_t         rt_content,
   input  word_t         result,
   output logic          busy,
   output logic          done,
   output logic          wb_en,
   output logic [4:0]    wb_addr,
   output word_t         wb_data
);
   state_t        state;
   logic [AW-1:0] pc;
   word_t         rf_rs;
   word_t         rf_rt;

   mips_regfile u_regfile (
      .clk     (clk),
      .reset   (reset),
      .we      (wb_en),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .raddr_a (instruction[25:21]),
      .raddr_b (instruction[20:16]),
      .rdata_a (rf_rs),
      .rdata_b (rf_rt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         pc          <= '0;
         imem_addr   <= '0;
         instruction <= '0;
         rs_content  <= '0;
         rt_content  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         wb_en       <= 1'b0;
         wb_addr     <= '0;
         wb_data     <= '0;
      end else begin
         wb_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_FETCH;
                  pc        <= '0;
                  imem_addr <= '0;
                  busy      <= 1'b1;
               end
            end
            ST_FETCH: state <= ST_DECODE;
            ST_DECODE: begin
               instruction <= imem_data;
               if (imem_data[31:26] == HALT_OPCODE) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               rs_content <= rf_rs;
               rt_content <= rf_rt;
               state      <= ST_EXEC;
            end
            // wb_data doubles as the result register; the write lands at the end of WB
            ST_EXEC: begin
               wb_data <= result;
               wb_addr <= (instruction[31:26] == OP_RTYPE) ? instruction[15:11]
                                                           : instruction[20:16];
               wb_en   <= 1'b1;
               state   <= ST_WB;
            end
            ST_WB: begin
               pc        <= pc + 1'b1;
               imem_addr <= pc + 1'b1;
               state     <= ST_FETCH;
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mips_issue_sequencer.sv
// Directed bench for mips_issue_sequencer with a behavioural core and synchronous instruction memory.
module tb_mips_issue_sequencer;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        start4 = 1'b0;

   logic [7:0]  imem_addr;
   word_t       imem_data;
   word_t       instruction, rs_content, rt_content, result, wb_data;
   logic        busy, done, wb_en;
   logic [4:0]  wb_addr;

   logic [1:0]  imem_addr4;
   word_t       imem_data4;
   word_t       instruction4, rs_content4, rt_content4, result4, wb_data4;
   logic        busy4, done4, wb_en4;
   logic [4:0]  wb_addr4;

   word_t       mem  [256];
   word_t       mem4 [4];

   logic [4:0]  log_a [$];
   word_t       log_d [$];

   int checks = 0;
   int errors = 0;
   int cnt;

   always #5 clk = ~clk;

   function automatic word_t core(input word_t ins, input word_t rs, input word_t rt);
      case (ins[31:26])
         OP_ADDI:  return rs + {{16{ins[15]}}, ins[15:0]};
         OP_RTYPE: return (ins[5:0] == FUNC_ADD) ? rs + rt : 32'd0;
         default:  return 32'd0;
      endcase
   endfunction

   assign result  = core(instruction,  rs_content,  rt_content);
   assign result4 = core(instruction4, rs_content4, rt_content4);

   always @(posedge clk) imem_data  <= mem[imem_addr];
   always @(posedge clk) imem_data4 <= mem4[imem_addr4];

   always @(negedge clk) begin
      if (wb_en === 1'b1) begin
         log_a.push_back(wb_addr);
         log_d.push_back(wb_data);
      end
   end

   mips_issue_sequencer dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .instruction(instruction), .rs_content(rs_content), .rt_content(rt_content),
      .result(result), .busy(busy), .done(done),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   mips_issue_sequencer #(.IMEM_DEPTH(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4),
      .imem_addr(imem_addr4), .imem_data(imem_data4),
      .instruction(instruction4), .rs_content(rs_content4), .rt_content(rt_content4),
      .result(result4), .busy(busy4), .done(done4),
      .wb_en(wb_en4), .wb_addr(wb_addr4), .wb_data(wb_data4)
   );

   task automatic check(input string tag, input word_t obs, input word_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load(input word_t w0, input word_t w1, input word_t w2, input word_t w3);
      for (int i = 0; i < 256; i++) mem[i] = 32'hFC00_0000;
      mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
      log_a.delete();
      log_d.delete();
   endtask

   // Pulses start, then counts negedges until done (or reset cutoff / budget).
   task automatic run(input int max, input int glitch_at, input int reset_at);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cnt = 0;
      while (cnt < max && done !== 1'b1) begin
         @(negedge clk);
         cnt++;
         start = (cnt == glitch_at);
         if (cnt == reset_at) reset = 1'b1;
         if (reset_at >= 0 && cnt == reset_at + 1) break;
      end
      start = 1'b0;
   endtask

   task automatic check_log(input string tag, input int n,
                            input logic [4:0] a0, input word_t d0,
                            input logic [4:0] a1, input word_t d1,
                            input logic [4:0] a2, input word_t d2);
      logic [4:0] ea [3];
      word_t      ed [3];
      ea = '{a0, a1, a2};
      ed = '{d0, d1, d2};
      check({tag, "_count"}, log_a.size(), n);
      for (int i = 0; i < n && i < log_a.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), {27'd0, log_a[i]}, {27'd0, ea[i]});
         check($sformatf("%s_data%0d", tag, i), log_d[i], ed[i]);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) mem4[i] = 32'h2021_0001;
      load(32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000);
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_wb_en", {31'd0, wb_en}, 32'd0);
      check("rst_instr", instruction, 32'd0);
      check("rst_rs", rs_content, 32'd0);
      check("rst_rt", rt_content, 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
      check("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);

      // addi/addi/add/halt
      load(32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hFC00_0000);
      run(200, -1, -1);
      check("t1_done_cycle", cnt, 17);
      check("t1_busy_at_done", {31'd0, busy}, 32'd1);
      check("t1_instr_halt", instruction, 32'hFC00_0000);
      check_log("t1", 3, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd12);
      @(negedge clk);
      check("t1_done_pulse", {31'd0, done}, 32'd0);
      check("t1_idle_busy", {31'd0, busy}, 32'd0);

      // same program with a stray start while busy
      load(32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hFC00_0000);
      run(200, 7, -1);
      check("t37_done_cycle", cnt, 17);
      check_log("t37", 3, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'd12);
      repeat (2) @(negedge clk);

      // writes to $0 are strobed but discarded
      load(32'h2000_0009, 32'h0000_0020, 32'hFC00_0000, 32'hFC00_0000);
      run(200, -1, -1);
      check("t34_done_cycle", cnt, 12);
      check_log("t34", 2, 5'd0, 32'd9, 5'd0, 32'd0, 5'd0, 32'd0);
      check("t34_rs_zero", rs_content, 32'd0);
      check("t34_rt_zero", rt_content, 32'd0);
      repeat (2) @(negedge clk);

      // read-after-write on $4
      load(32'h2004_0001, 32'h0084_2020, 32'hFC00_0000, 32'hFC00_0000);
      run(200, -1, -1);
      check_log("t35", 2, 5'd4, 32'd1, 5'd4, 32'd2, 5'd0, 32'd0);
      check("t35_rs", rs_content, 32'd1);
      repeat (2) @(negedge clk);

      // reset during EXEC of the second instruction
      load(32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hFC00_0000);
      run(200, -1, 8);
      check("t36_busy", {31'd0, busy}, 32'd0);
      check("t36_wb_en", {31'd0, wb_en}, 32'd0);
      check("t36_instr", instruction, 32'd0);
      check("t36_rs", rs_content, 32'd0);
      check("t36_wb_data", wb_data, 32'd0);
      check_log("t36", 1, 5'd1, 32'd5, 5'd0, 32'd0, 5'd0, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("t36_still_idle", {31'd0, busy}, 32'd0);
      load(32'h0022_1820, 32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000);
      run(200, -1, -1);
      check("t36_r1_cleared", rs_content, 32'd0);
      check("t36_r2_cleared", rt_content, 32'd0);
      check_log("t36b", 1, 5'd3, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
      repeat (2) @(negedge clk);

      // pc wrap on the depth-4 instance
      @(negedge clk); start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      for (int k = 0; k <= 25; k++) begin
         if (k % 5 == 0)
            check($sformatf("t38_pc%0d", k / 5), {30'd0, imem_addr4}, (k / 5) % 4);
         @(negedge clk);
      end
      check("t38_busy", {31'd0, busy4}, 32'd1);
      check("t38_no_done", {31'd0, done4}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
